// File: rtl/regfile_rename_pkg.sv
// Shared widths, sizes and array types for the register file / rename table.
// Optional same-cycle commit bypass is enabled with REGFILE_COMMIT_BYPASS_EN.
package regfile_rename_pkg;

    localparam int DATA_W    = 32;
    localparam int TAG_W     = 5;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [TAG_W-1:0]     tag_t;
    typedef logic [REG_IDX_W-1:0] idx_t;

    // Tag 0 is reserved to mean "no producer".
    localparam tag_t  EMPTY_TAG  = '0;
    localparam data_t EMPTY_DATA = '0;

    typedef data_t reg_arr_t [NREG];
    typedef tag_t  tag_arr_t [NREG];

endpackage

// File: rtl/regfile_rename_if.sv
// Decoder read/rename and ROB commit signals of the register file.
// Handshake: no back-pressure; rename_en/commit_en are single-cycle strobes taken when rdy=1.
interface regfile_rename_if;
    import regfile_rename_pkg::*;

    idx_t  rs1_addr;
    logic  rs1_busy;
    tag_t  rs1_tag;
    data_t rs1_data;

    idx_t  rs2_addr;
    logic  rs2_busy;
    tag_t  rs2_tag;
    data_t rs2_data;

    logic  rename_en;
    idx_t  rename_rd;
    tag_t  rename_tag;

    logic  commit_en;
    idx_t  commit_rd;
    data_t commit_data;
    tag_t  commit_tag;

    modport master (
        output rs1_addr, rs2_addr,
        output rename_en, rename_rd, rename_tag,
        output commit_en, commit_rd, commit_data, commit_tag,
        input  rs1_busy, rs1_tag, rs1_data,
        input  rs2_busy, rs2_tag, rs2_data
    );

    modport slave (
        input  rs1_addr, rs2_addr,
        input  rename_en, rename_rd, rename_tag,
        input  commit_en, commit_rd, commit_data, commit_tag,
        output rs1_busy, rs1_tag, rs1_data,
        output rs2_busy, rs2_tag, rs2_data
    );

endinterface

// File: rtl/regfile_read_port.sv
// Combinational operand read: value when idle, producer tag when busy.
// With REGFILE_COMMIT_BYPASS_EN a matching commit in flight is forwarded as the value.
module regfile_read_port
    import regfile_rename_pkg::*;
(
    input  idx_t             addr,
    input  logic [NREG-1:0]  busy_vec,
    input  tag_arr_t         tag_tab,
    input  reg_arr_t         regs,
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  logic             rdy,
    input  logic             commit_en,
    input  idx_t             commit_rd,
    input  tag_t             commit_tag,
    input  data_t            commit_data,
`endif
    output logic             busy,
    output tag_t             tag,
    output data_t            data
);

    always_comb begin
        busy = 1'b0;
        tag  = EMPTY_TAG;
        data = EMPTY_DATA;
        if (addr != '0) begin
            if (busy_vec[addr]) begin
                busy = 1'b1;
                tag  = tag_tab[addr];
            end else begin
                data = regs[addr];
            end
`ifdef REGFILE_COMMIT_BYPASS_EN
            // The producer retires this cycle: hand out its value instead of a dying tag.
            if (rdy && commit_en && commit_rd == addr && busy_vec[addr]
                && tag_tab[addr] == commit_tag) begin
                busy = 1'b0;
                tag  = EMPTY_TAG;
                data = commit_data;
            end
`endif
        end
    end

endmodule

// File: rtl/regfile_rename.sv
// Architectural register file plus rename tag table fed by ROB commits.
// Define REGFILE_COMMIT_BYPASS_EN to forward retiring values to the read ports.
module regfile_rename
    import regfile_rename_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,
    regfile_rename_if.slave   bus,
    output logic [NREG-1:0]   busy_dbg
);

    reg_arr_t         regs;
    tag_arr_t         tag_tab;
    logic [NREG-1:0]  busy;

    logic commit_release;
    logic rename_take;

    assign commit_release = bus.commit_en && busy[bus.commit_rd]
                            && tag_tab[bus.commit_rd] == bus.commit_tag;
    assign rename_take    = bus.rename_en && bus.rename_rd != '0;
    assign busy_dbg       = busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i]    <= EMPTY_DATA;
                tag_tab[i] <= EMPTY_TAG;
            end
        end else if (rdy) begin
            // Committed data is architectural and lands even during a flush.
            if (bus.commit_en && bus.commit_rd != '0)
                regs[bus.commit_rd] <= bus.commit_data;
            if (clear) begin
                busy <= '0;
                for (int i = 0; i < NREG; i++)
                    tag_tab[i] <= EMPTY_TAG;
            end else begin
                if (commit_release) begin
                    busy[bus.commit_rd]    <= 1'b0;
                    tag_tab[bus.commit_rd] <= EMPTY_TAG;
                end
                // Placed after the release so a same-rd rename keeps its new tag.
                if (rename_take) begin
                    busy[bus.rename_rd]    <= 1'b1;
                    tag_tab[bus.rename_rd] <= bus.rename_tag;
                end
            end
        end
    end

    regfile_read_port u_rs1 (
        .addr        (bus.rs1_addr),
        .busy_vec    (busy),
        .tag_tab     (tag_tab),
        .regs        (regs),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .rdy         (rdy),
        .commit_en   (bus.commit_en),
        .commit_rd   (bus.commit_rd),
        .commit_tag  (bus.commit_tag),
        .commit_data (bus.commit_data),
`endif
        .busy        (bus.rs1_busy),
        .tag         (bus.rs1_tag),
        .data        (bus.rs1_data)
    );

    regfile_read_port u_rs2 (
        .addr        (bus.rs2_addr),
        .busy_vec    (busy),
        .tag_tab     (tag_tab),
        .regs        (regs),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .rdy         (rdy),
        .commit_en   (bus.commit_en),
        .commit_rd   (bus.commit_rd),
        .commit_tag  (bus.commit_tag),
        .commit_data (bus.commit_data),
`endif
        .busy        (bus.rs2_busy),
        .tag         (bus.rs2_tag),
        .data        (bus.rs2_data)
    );

endmodule
